fetch_pc_unit: RTL and testbench



---
 rtl/core_pkg.sv | 65 ++++++
 rtl/next_pc_calc.sv | 43 ++++
 rtl/fetch_pc_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// ============================================================================
// core_pkg : shared core types (cuOPType, fetch state) and decode helpers
// Revision : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

  // Ordering is shared with signExtender and the control unit; append only.
  typedef enum logic [5:0] {
    CU_LUI    = 6'd0,
    CU_AUIPC  = 6'd1,
    CU_JAL    = 6'd2,
    CU_JALR   = 6'd3,
    CU_BEQ    = 6'd4,
    CU_BNE    = 6'd5,
    CU_BLT    = 6'd6,
    CU_BGE    = 6'd7,
    CU_BLTU   = 6'd8,
    CU_BGEU   = 6'd9,
    CU_LB     = 6'd10,
    CU_LH     = 6'd11,
    CU_LW     = 6'd12,
    CU_LBU    = 6'd13,
    CU_LHU    = 6'd14,
    CU_SB     = 6'd15,
    CU_SH     = 6'd16,
    CU_SW     = 6'd17,
    CU_ADDI   = 6'd18,
    CU_SLTI   = 6'd19,
    CU_SLTIU  = 6'd20,
    CU_XORI   = 6'd21,
    CU_ORI    = 6'd22,
    CU_ANDI   = 6'd23,
    CU_SLLI   = 6'd24,
    CU_SRLI   = 6'd25,
    CU_SRAI   = 6'd26,
    CU_ADD    = 6'd27,
    CU_SUB    = 6'd28,
    CU_SLL    = 6'd29,
    CU_SLT    = 6'd30,
    CU_SLTU   = 6'd31,
    CU_XOR    = 6'd32,
    CU_SRL    = 6'd33,
    CU_SRA    = 6'd34,
    CU_OR     = 6'd35,
    CU_AND    = 6'd36,
    CU_FENCE  = 6'd37,
    CU_ECALL  = 6'd38,
    CU_EBREAK = 6'd39
  } cuOPType;

  typedef enum logic [1:0] {
    FS_FETCH  = 2'd0,
    FS_EXEC   = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic isBranch(input logic [5:0] op);
    return (op >= 6'(CU_BEQ)) && (op <= 6'(CU_BGEU));
  endfunction

endpackage : core_pkg

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// next_pc_calc : combinational next-PC / link-address / alignment check
// Revision     : 1.0
// ============================================================================
`default_nettype none

module next_pc_calc
  import core_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [5:0]  CUOp_i,
  input  logic [31:0] immOut_i,
  input  logic [31:0] rs1Data_i,
  input  logic        branchTaken_i,
  output logic [31:0] nextPc_o,
  output logic [31:0] linkAddr_o,
  output logic        misalign_o
);

  logic [31:0] seq_pc;
  logic [31:0] rel_pc;
  logic [31:0] jalr_sum;

  assign seq_pc   = pc_i + 32'd4;
  assign rel_pc   = pc_i + immOut_i;
  assign jalr_sum = rs1Data_i + immOut_i;

  always_comb begin
    nextPc_o = seq_pc;
    if ((CUOp_i == 6'(CU_JAL)) || (isBranch(CUOp_i) && branchTaken_i)) begin
      nextPc_o = rel_pc;
    end else if (CUOp_i == 6'(CU_JALR)) begin
      nextPc_o = {jalr_sum[31:1], 1'b0};
    end
  end

  // Only bit 1 can still be set for JALR after bit 0 is cleared.
  assign misalign_o = |nextPc_o[1:0];
  assign linkAddr_o = seq_pc;

endmodule : next_pc_calc

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// fetch_pc_unit : PC register plus FETCH/EXEC/HALTED instruction sequencer.
// Optional macro FETCH_TIMEOUT_EN adds a fetch wait timeout and fetchErr.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module fetch_pc_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  CUOp,
  input  logic [31:0] immOut,
  input  logic [31:0] rs1Data,
  input  logic        branchTaken,
  input  logic        halt,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  output logic [31:0] pc,
  output logic [31:0] linkAddr,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic        misalign,
  output logic        halted
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic        fetchErr
`endif
);

  localparam logic [1:0] ST_FETCH  = FS_FETCH;
  localparam logic [1:0] ST_EXEC   = FS_EXEC;
  localparam logic [1:0] ST_HALTED = FS_HALTED;

  logic [1:0]  state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] instr_q,    instr_d;
  logic        misalign_q, misalign_d;

  logic [31:0] next_pc;
  logic        next_misalign;

  next_pc_calc u_next_pc_calc (
    .pc_i          (pc_q),
    .CUOp_i        (CUOp),
    .immOut_i      (immOut),
    .rs1Data_i     (rs1Data),
    .branchTaken_i (branchTaken),
    .nextPc_o      (next_pc),
    .linkAddr_o    (linkAddr),
    .misalign_o    (next_misalign)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned       WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fetchErr_q, fetchErr_d;

  // Counter is zero on every FETCH entry because it clears outside FETCH.
  assign wait_d = ((state_q == ST_FETCH) && !imemAck) ? (wait_q + WAIT_W'(1)) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q     <= '0;
      fetchErr_q <= 1'b0;
    end else begin
      wait_q     <= wait_d;
      fetchErr_q <= fetchErr_d;
    end
  end

  assign fetchErr = fetchErr_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
`ifdef FETCH_TIMEOUT_EN
    fetchErr_d = fetchErr_q;
`endif
    case (state_q)
      ST_FETCH: begin
        if (imemAck) begin
          instr_d = imemRdata;
          state_d = ST_EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          fetchErr_d = 1'b1;
          state_d    = ST_HALTED;
        end
`endif
      end
      ST_EXEC: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (next_misalign) begin
          misalign_d = 1'b1;
          state_d    = ST_HALTED;
        end else begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

  // Status strobes are masked during rst so the reset cycle issues nothing.
  assign imemReq    = (state_q == ST_FETCH)  && !rst;
  assign instrValid = (state_q == ST_EXEC)   && !rst;
  assign halted     = (state_q == ST_HALTED) && !rst;
  assign imemAddr   = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign misalign   = misalign_q;

endmodule : fetch_pc_unit

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// tb_fetch_pc_unit : directed self-checking bench for fetch_pc_unit
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  CUOp = 6'(CU_ADD);
  logic [31:0] immOut = '0;
  logic [31:0] rs1Data = '0;
  logic        branchTaken = 1'b0;
  logic        halt = 1'b0;
  logic        imemAck = 1'b0;
  logic [31:0] imemRdata = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] pc;
  logic [31:0] linkAddr;
  logic [31:0] instr;
  logic        instrValid;
  logic        misalign;
  logic        halted;
`ifdef FETCH_TIMEOUT_EN
  logic        fetchErr;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .CUOp        (CUOp),
    .immOut      (immOut),
    .rs1Data     (rs1Data),
    .branchTaken (branchTaken),
    .halt        (halt),
    .imemAck     (imemAck),
    .imemRdata   (imemRdata),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .pc          (pc),
    .linkAddr    (linkAddr),
    .instr       (instr),
    .instrValid  (instrValid),
    .misalign    (misalign),
    .halted      (halted)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetchErr    (fetchErr)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imemAck = 1'b0; halt = 1'b0; branchTaken = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // From FETCH: ack immediately, leaving the DUT in EXEC.
  task automatic give_ack(input logic [31:0] data);
    imemAck = 1'b1; imemRdata = data;
    tick();
    imemAck = 1'b0;
    #1;
  endtask

  // From EXEC: apply an op for one cycle, leaving the DUT in its next state.
  task automatic exec_op(input logic [5:0] op, input logic [31:0] imm);
    CUOp = op; immOut = imm;
    tick();
    CUOp = 6'(CU_ADD); immOut = '0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imemAck = 1'b1; imemRdata = 32'hDEAD_BEEF;
    tick();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr, 32'h0); end
    total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imemReq); end
    total++; if ({instrValid, halted, misalign} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {instrValid, halted, misalign});
    end
    tick();
    rst = 1'b0; imemAck = 1'b0;
    #1;
    total++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      bad++; $display("FAIL first_fetch got req=%b addr=%h exp req=1 addr=0", imemReq, imemAddr);
    end
  endtask

  task automatic test_seq_fetch();
    give_ack(32'h1111_0001);
    total++; if (instrValid !== 1'b1 || instr !== 32'h1111_0001) begin
      bad++; $display("FAIL seq_exec0 got v=%b instr=%h exp v=1 instr=11110001", instrValid, instr);
    end
    total++; if (pc !== 32'h0 || linkAddr !== 32'h4 || imemReq !== 1'b0) begin
      bad++; $display("FAIL seq_exec0_pc got pc=%h link=%h req=%b exp 0/4/0", pc, linkAddr, imemReq);
    end
    // ack during EXEC must be ignored
    imemAck = 1'b1; imemRdata = 32'hBADB_AD00;
    tick();
    imemAck = 1'b0;
    #1;
    total++; if (imemReq !== 1'b1 || imemAddr !== 32'h4 || instrValid !== 1'b0) begin
      bad++; $display("FAIL seq_fetch1 got req=%b addr=%h v=%b exp 1/4/0", imemReq, imemAddr, instrValid);
    end
    total++; if (instr !== 32'h1111_0001) begin
      bad++; $display("FAIL ack_in_exec got=%h exp=11110001", instr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imemReq !== 1'b1 || instrValid !== 1'b0) begin
        bad++; $display("FAIL seq_wait%0d got req=%b v=%b exp 1/0", i, imemReq, instrValid);
      end
    end
    give_ack(32'h2222_0002);
    total++; if (instrValid !== 1'b1 || instr !== 32'h2222_0002 || pc !== 32'h4) begin
      bad++; $display("FAIL seq_exec1 got v=%b instr=%h pc=%h exp 1/22220002/4", instrValid, instr, pc);
    end
    exec_op(6'(CU_ADD), 32'h0);
    total++; if (imemAddr !== 32'h8 || instrValid !== 1'b0) begin
      bad++; $display("FAIL seq_fetch2 got addr=%h v=%b exp 8/0", imemAddr, instrValid);
    end
  endtask

  task automatic test_jal();
    give_ack(32'h0000_006F);
    exec_op(6'(CU_JAL), 32'h0000_00F8);
    total++; if (imemAddr !== 32'h100) begin bad++; $display("FAIL jal_to_100 got=%h exp=100", imemAddr); end
    give_ack(32'h0100_006F);
    CUOp = 6'(CU_JAL); immOut = 32'h10;
    #1;
    total++; if (linkAddr !== 32'h104) begin bad++; $display("FAIL jal_link got=%h exp=104", linkAddr); end
    tick();
    CUOp = 6'(CU_ADD); immOut = '0;
    #1;
    total++; if (imemAddr !== 32'h110 || imemReq !== 1'b1) begin
      bad++; $display("FAIL jal_target got addr=%h req=%b exp 110/1", imemAddr, imemReq);
    end
  endtask

  task automatic test_jalr();
    give_ack(32'h0000_0067);
    CUOp = 6'(CU_JALR); rs1Data = 32'h2001; immOut = 32'h4;
    tick();
    CUOp = 6'(CU_ADD); rs1Data = '0; immOut = '0;
    #1;
    total++; if (pc !== 32'h2004 || misalign !== 1'b0) begin
      bad++; $display("FAIL jalr_target got pc=%h mis=%b exp 2004/0", pc, misalign);
    end
  endtask

  task automatic test_branch();
    give_ack(32'h0);
    exec_op(6'(CU_JAL), 32'hFFFF_E01C);
    total++; if (pc !== 32'h20) begin bad++; $display("FAIL br_setup got=%h exp=20", pc); end
    give_ack(32'h0);
    branchTaken = 1'b1;
    exec_op(6'(CU_BNE), 32'hFFFF_FFF8);
    total++; if (pc !== 32'h18) begin bad++; $display("FAIL bne_taken got=%h exp=18", pc); end
    branchTaken = 1'b0;
    give_ack(32'h0);
    exec_op(6'(CU_JAL), 32'h8);
    give_ack(32'h0);
    exec_op(6'(CU_BNE), 32'hFFFF_FFF8);
    total++; if (pc !== 32'h24) begin bad++; $display("FAIL bne_not_taken got=%h exp=24", pc); end
    give_ack(32'h0);
    branchTaken = 1'b1;
    exec_op(6'(CU_ADD), 32'h100);
    total++; if (pc !== 32'h28) begin bad++; $display("FAIL add_ignores_taken got=%h exp=28", pc); end
    give_ack(32'h0);
    exec_op(6'(CU_BGEU), 32'h8);
    total++; if (pc !== 32'h30) begin bad++; $display("FAIL bgeu_taken got=%h exp=30", pc); end
    branchTaken = 1'b0;
  endtask

  task automatic test_wrap();
    give_ack(32'h0);
    exec_op(6'(CU_JAL), 32'hFFFF_FFCC);
    total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_setup got=%h exp=fffffffc", pc); end
    give_ack(32'h0);
    total++; if (linkAddr !== 32'h0) begin bad++; $display("FAIL wrap_link got=%h exp=0", linkAddr); end
    exec_op(6'(CU_ADD), 32'h0);
    total++; if (pc !== 32'h0 || imemReq !== 1'b1) begin
      bad++; $display("FAIL wrap_pc got pc=%h req=%b exp 0/1", pc, imemReq);
    end
  endtask

  task automatic test_reset_mid_fetch();
    give_ack(32'h3333_0003);
    exec_op(6'(CU_ADD), 32'h0);
    rst = 1'b1; imemAck = 1'b1; imemRdata = 32'hBADC_0DE0;
    tick();
    total++; if (instr !== 32'h0 || pc !== 32'h0) begin
      bad++; $display("FAIL rst_mid_fetch got instr=%h pc=%h exp 0/0", instr, pc);
    end
    total++; if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_req got req=%b v=%b exp 0/0", imemReq, instrValid);
    end
    rst = 1'b0; imemAck = 1'b0;
    #1;
    total++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      bad++; $display("FAIL rst_refetch got req=%b addr=%h exp 1/0", imemReq, imemAddr);
    end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    tick(); tick();
    total++; if (imemReq !== 1'b1 || halted !== 1'b0) begin
      bad++; $display("FAIL halt_in_fetch got req=%b halted=%b exp 1/0", imemReq, halted);
    end
    give_ack(32'h0000_0073);
    exec_op(6'(CU_JAL), 32'h40);
    total++; if (halted !== 1'b1 || misalign !== 1'b0 || pc !== 32'h0 || imemReq !== 1'b0) begin
      bad++; $display("FAIL halt_exec got h=%b m=%b pc=%h req=%b exp 1/0/0/0", halted, misalign, pc, imemReq);
    end
    halt = 1'b0; imemAck = 1'b1;
    tick(); tick();
    imemAck = 1'b0;
    #1;
    total++; if (halted !== 1'b1 || imemReq !== 1'b0 || instrValid !== 1'b0) begin
      bad++; $display("FAIL halt_sticky got h=%b req=%b v=%b exp 1/0/0", halted, imemReq, instrValid);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    give_ack(32'h0);
    exec_op(6'(CU_JAL), 32'h40);
    give_ack(32'h0);
    exec_op(6'(CU_JAL), 32'h2);
    total++; if (misalign !== 1'b1 || halted !== 1'b1 || pc !== 32'h40) begin
      bad++; $display("FAIL misalign_trap got m=%b h=%b pc=%h exp 1/1/40", misalign, halted, pc);
    end
    imemAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imemReq !== 1'b0 || pc !== 32'h40) begin
        bad++; $display("FAIL misalign_hold%0d got req=%b pc=%h exp 0/40", i, imemReq, pc);
      end
    end
    imemAck = 1'b0;
    do_reset();
    total++; if (misalign !== 1'b0 || halted !== 1'b0) begin
      bad++; $display("FAIL misalign_clear got m=%b h=%b exp 0/0", misalign, halted);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    total++; if (fetchErr !== 1'b0) begin bad++; $display("FAIL to_reset got=%b exp=0", fetchErr); end
    repeat (15) tick();
    total++; if (fetchErr !== 1'b0 || imemReq !== 1'b1) begin
      bad++; $display("FAIL to_early got err=%b req=%b exp 0/1", fetchErr, imemReq);
    end
    tick();
    total++; if (fetchErr !== 1'b1 || halted !== 1'b1) begin
      bad++; $display("FAIL to_fire got err=%b h=%b exp 1/1", fetchErr, halted);
    end
    do_reset();
    repeat (15) tick();
    give_ack(32'h4444_0004);
    total++; if (fetchErr !== 1'b0 || instrValid !== 1'b1) begin
      bad++; $display("FAIL to_ack_wins got err=%b v=%b exp 0/1", fetchErr, instrValid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_seq_fetch();
    test_jal();
    test_jalr();
    test_branch();
    test_wrap();
    test_reset_mid_fetch();
    test_halt();
    test_misalign();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_pc_unit

`default_nettype wire
